// File: rtl/adc128_spi_ctrl.sv
// rtl/adc128_spi_ctrl.sv - ADC128S022 SPI conversion frame controller
// A single-cycle start runs one 16-SCLK frame; the 12-bit result returns with a one-cycle strobe.
module adc128_spi_ctrl #(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic        data_valid,
  output logic [11:0] data,
  output logic [2:0]  data_channel,
  output logic        adc_cs_n,
  output logic        adc_saddr,
  output logic        adc_sclk,
  input  logic        adc_sdat
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_k, bit_k_nxt, k_inc;
  logic [2:0]       cur_ch, cur_ch_nxt, prev_ch, prev_ch_nxt;
  logic [11:0]      shreg, shreg_nxt, data_nxt;
  logic [2:0]       data_channel_nxt;
  logic             busy_nxt, data_valid_nxt, cs_n_nxt, saddr_nxt, sclk_nxt;
  logic             tc, last_bit, saddr_k;

  assign tc       = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_bit = (bit_k == 4'd15);
  assign k_inc    = bit_k + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_k        <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      shreg        <= '0;
      busy         <= 1'b0;
      data_valid   <= 1'b0;
      data         <= '0;
      data_channel <= '0;
      adc_cs_n     <= 1'b1;
      adc_saddr    <= 1'b0;
      adc_sclk     <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_k        <= bit_k_nxt;
      cur_ch       <= cur_ch_nxt;
      prev_ch      <= prev_ch_nxt;
      shreg        <= shreg_nxt;
      busy         <= busy_nxt;
      data_valid   <= data_valid_nxt;
      data         <= data_nxt;
      data_channel <= data_channel_nxt;
      adc_cs_n     <= cs_n_nxt;
      adc_saddr    <= saddr_nxt;
      adc_sclk     <= sclk_nxt;
    end
  end

  // adc_sclk doubles as the SHIFT phase flag: low phase ends in a rise, high phase in a fall.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tc) state_nxt = SHIFT;
      SHIFT:   if (tc && adc_sclk && last_bit) state_nxt = HOLD;
      HOLD:    if (tc) state_nxt = QUIET;
      QUIET:   if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (k_inc)
      4'd2:    saddr_k = cur_ch[2];
      4'd3:    saddr_k = cur_ch[1];
      4'd4:    saddr_k = cur_ch[0];
      default: saddr_k = 1'b0;
    endcase
  end

  always_comb begin
    cnt_nxt          = (state == IDLE || tc) ? '0 : cnt + CNT_W'(1);
    bit_k_nxt        = bit_k;
    cur_ch_nxt       = cur_ch;
    prev_ch_nxt      = prev_ch;
    shreg_nxt        = shreg;
    busy_nxt         = busy;
    data_valid_nxt   = 1'b0;
    data_nxt         = data;
    data_channel_nxt = data_channel;
    cs_n_nxt         = adc_cs_n;
    saddr_nxt        = adc_saddr;
    sclk_nxt         = adc_sclk;
    case (state)
      IDLE: if (start) begin
        busy_nxt   = 1'b1;
        cs_n_nxt   = 1'b0;
        sclk_nxt   = 1'b1;
        cur_ch_nxt = channel;
      end
      SETUP: if (tc) begin
        sclk_nxt  = 1'b0;
        saddr_nxt = 1'b0;
        bit_k_nxt = '0;
      end
      SHIFT: if (tc) begin
        if (!adc_sclk) begin
          sclk_nxt = 1'b1;
          if (bit_k[3:2] != 2'b00) shreg_nxt = {shreg[10:0], adc_sdat};
        end else if (!last_bit) begin
          sclk_nxt  = 1'b0;
          bit_k_nxt = k_inc;
          saddr_nxt = saddr_k;
        end
      end
      // The ADC returns the conversion addressed during the previous frame.
      HOLD: if (tc) begin
        cs_n_nxt         = 1'b1;
        saddr_nxt        = 1'b0;
        data_valid_nxt   = 1'b1;
        data_nxt         = shreg;
        data_channel_nxt = prev_ch;
        prev_ch_nxt      = cur_ch;
      end
      QUIET: if (tc) busy_nxt = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_adc128_spi_ctrl.sv
// tb/tb_adc128_spi_ctrl.sv - directed bench for adc128_spi_ctrl
// Bus-level ADC models feed DOUT on falling SCLK and record DIN/edges for both instances.
module tb_adc128_spi_ctrl;
  localparam int D = 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, adc_sdat = 1'b0;
  logic [2:0] channel = '0;
  logic busy, data_valid, adc_cs_n, adc_saddr, adc_sclk;
  logic [11:0] data;
  logic [2:0] data_channel;

  logic start16 = 1'b0, sdat16 = 1'b1;
  logic [2:0] channel16 = '0;
  logic busy16, data_valid16, cs16, saddr16, sclk16;
  logic [11:0] data16;
  logic [2:0] dch16;

  always #5 clk = ~clk;

  adc128_spi_ctrl #(.CLK_DIV(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .channel(channel), .busy(busy),
    .data_valid(data_valid), .data(data), .data_channel(data_channel),
    .adc_cs_n(adc_cs_n), .adc_saddr(adc_saddr), .adc_sclk(adc_sclk), .adc_sdat(adc_sdat));

  adc128_spi_ctrl dut16 (
    .clk(clk), .reset(reset), .start(start16), .channel(channel16), .busy(busy16),
    .data_valid(data_valid16), .data(data16), .data_channel(dch16),
    .adc_cs_n(cs16), .adc_saddr(saddr16), .adc_sclk(sclk16), .adc_sdat(sdat16));

  int checks = 0, failures = 0;
  logic [15:0] adc_word = '0, sh = '0, din_word = '0;
  int rises = 0, falls = 0, per_err = 0, nvalid = 0, hi_run = 0, last_gap = 0;
  int rises16 = 0, per_err16 = 0;
  time t_last = 0, t_last16 = 0;
  logic cs_at1, cs_lo, cs_hi;

  always @(negedge adc_cs_n) begin
    rises = 0; falls = 0; din_word = '0; per_err = 0; sh = adc_word;
  end
  always @(negedge adc_sclk) if (!adc_cs_n) begin
    adc_sdat = sh[15]; sh = {sh[14:0], 1'b0}; falls++;
  end
  always @(posedge adc_sclk) if (!adc_cs_n) begin
    din_word = {din_word[14:0], adc_saddr};
    if (rises > 0 && ($time - t_last) != 2 * D * 10) per_err++;
    t_last = $time; rises++;
  end
  always @(negedge clk) begin
    if (data_valid) nvalid++;
    if (adc_cs_n) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end
  always @(negedge cs16) begin rises16 = 0; per_err16 = 0; end
  always @(posedge sclk16) if (!cs16) begin
    if (rises16 > 0 && ($time - t_last16) != 320) per_err16++;
    t_last16 = $time; rises16++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then reports cycles (from acceptance) to data_valid and to busy low.
  task automatic run_frame(input logic [2:0] ch, input logic [15:0] w, input int poke,
                           output int tv, output int tb);
    int n;
    adc_word = w;
    @(negedge clk); start = 1'b1; channel = ch;
    @(negedge clk); start = 1'b0; n = 1; tv = -1; tb = -1;
    while (n < 1000 && tb < 0) begin
      if (n == 1) cs_at1 = adc_cs_n;
      if (n == 34 * D) cs_lo = adc_cs_n;
      if (n == 34 * D + 1) cs_hi = adc_cs_n;
      if (data_valid && tv < 0) tv = n;
      if (!busy) tb = n;
      if (n == poke) begin start = 1'b1; channel = 3'd6; end
      else if (n == poke + 1) start = 1'b0;
      @(negedge clk); n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!data_valid && n < 1000) begin @(negedge clk); n++; end
    if (!data_valid) n = -1;
  endtask

  task automatic wait_accept(output int n);
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    while (!busy && n < 1000) begin @(negedge clk); n++; end
    if (!busy) n = -1;
  endtask

  initial begin
    int tv, tb, n, nv0, bcnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_dch", 32'(data_channel), 0);
    chk("rst_cs_n", 32'(adc_cs_n), 1);
    chk("rst_saddr", 32'(adc_saddr), 0);
    chk("rst_sclk", 32'(adc_sclk), 1);
    start = 1'b1; channel = 3'd5;
    @(negedge clk);
    chk("rst_wins_busy", 32'(busy), 0);
    chk("rst_wins_cs_n", 32'(adc_cs_n), 1);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: channel 3, ADC word 0x0AC3
    nv0 = nvalid;
    run_frame(3'd3, 16'h0AC3, 0, tv, tb);
    chk("f1_cs_at1", 32'(cs_at1), 0);
    chk("f1_cs_last_low", 32'(cs_lo), 0);
    chk("f1_cs_high_at_valid", 32'(cs_hi), 1);
    chk("f1_valid_cycle", tv, 137);
    chk("f1_busy_low_cycle", tb, 141);
    chk("f1_data", 32'(data), 32'hAC3);
    chk("f1_dch", 32'(data_channel), 0);
    chk("f1_rises", rises, 16);
    chk("f1_falls", falls, 16);
    chk("f1_period_err", per_err, 0);
    chk("f1_din", 32'(din_word), 32'h1800);
    chk("f1_nvalid", nvalid - nv0, 1);

    // Frame 2: channel 5, ADC word 0x07FF
    run_frame(3'd5, 16'h07FF, 0, tv, tb);
    chk("f2_valid_cycle", tv, 137);
    chk("f2_data", 32'(data), 32'h7FF);
    chk("f2_dch", 32'(data_channel), 3);
    chk("f2_din", 32'(din_word), 32'h2800);

    // Frame 3: channel 1, start with channel 6 pulsed mid-frame
    nv0 = nvalid;
    run_frame(3'd1, 16'h0123, 10, tv, tb);
    chk("f3_valid_cycle", tv, 137);
    chk("f3_data", 32'(data), 32'h123);
    chk("f3_dch", 32'(data_channel), 5);
    chk("f3_din", 32'(din_word), 32'h0800);
    bcnt = 0;
    repeat (60) begin @(negedge clk); if (busy || !adc_cs_n) bcnt++; end
    chk("f3_no_second_frame", bcnt, 0);
    chk("f3_nvalid", nvalid - nv0, 1);

    // Frames 4a-c: start held high, channels 2, 4, 7
    nv0 = nvalid;
    adc_word = 16'h0111;
    @(negedge clk); start = 1'b1; channel = 3'd2;
    @(negedge clk); channel = 3'd4;
    wait_valid(n);
    chk("f4a_timeout", 32'(n >= 0), 1);
    chk("f4a_data", 32'(data), 32'h111);
    chk("f4a_dch", 32'(data_channel), 1);
    adc_word = 16'h0222;
    wait_accept(n);
    chk("f4b_accept_timeout", 32'(n >= 0), 1);
    channel = 3'd7;
    wait_valid(n);
    chk("f4b_gap", last_gap, D + 1);
    chk("f4b_data", 32'(data), 32'h222);
    chk("f4b_dch", 32'(data_channel), 2);
    adc_word = 16'h0333;
    last_gap = 0;
    wait_accept(n);
    start = 1'b0;
    wait_valid(n);
    chk("f4c_gap", last_gap, D + 1);
    chk("f4c_data", 32'(data), 32'h333);
    chk("f4c_dch", 32'(data_channel), 4);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("f4_busy_done", 32'(busy), 0);
    chk("f4_nvalid", nvalid - nv0, 3);

    // Frame 5: reset at the 7th SCLK rise, then a clean frame on channel 2
    nv0 = nvalid;
    adc_word = 16'hFFFF;
    @(negedge clk); start = 1'b1; channel = 3'd3;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (rises < 7 && n < 200) begin @(negedge clk); n++; end
    chk("f5_reached_rise7", rises, 7);
    reset = 1'b1;
    @(negedge clk);
    chk("f5_cs_n", 32'(adc_cs_n), 1);
    chk("f5_sclk", 32'(adc_sclk), 1);
    chk("f5_busy", 32'(busy), 0);
    chk("f5_valid", 32'(data_valid), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("f5_no_valid", nvalid - nv0, 0);
    run_frame(3'd2, 16'h0456, 0, tv, tb);
    chk("f5_valid_cycle", tv, 137);
    chk("f5_data", 32'(data), 32'h456);
    chk("f5_dch", 32'(data_channel), 0);

    // Default CLK_DIV=16 instance
    @(negedge clk); start16 = 1'b1; channel16 = 3'd0;
    @(negedge clk); start16 = 1'b0; n = 1; tv = -1; tb = -1;
    while (n < 2000 && tb < 0) begin
      if (data_valid16 && tv < 0) tv = n;
      if (!busy16) tb = n;
      @(negedge clk); n++;
    end
    chk("d16_valid_cycle", tv, 545);
    chk("d16_busy_low_cycle", tb, 561);
    chk("d16_data", 32'(data16), 32'hFFF);
    chk("d16_dch", 32'(dch16), 0);
    chk("d16_rises", rises16, 16);
    chk("d16_period_err", per_err16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
